// File: rtl/exec_unit_md.sv
// Execution unit: single-cycle ALU and branch resolution, plus an iterative
// radix-2 multiply/divide/remainder engine with its own writeback channel.
module exec_unit_md #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned PC_W     = 14,
   parameter int unsigned RA_W     = 6,
   parameter int unsigned LINK_REG = 31
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   input  logic            flush,
   input  logic [PC_W-1:0] pc,
   input  logic [5:0]      ope,
   input  logic [XLEN-1:0] ds_val,
   input  logic [XLEN-1:0] dt_val,
   input  logic [RA_W-1:0] dd,
   input  logic [15:0]     imm,
   input  logic [4:0]      opr,
   input  logic            pred_taken,
   output logic            busy,
   output logic [RA_W-1:0] alu_addr,
   output logic [XLEN-1:0] alu_val,
   output logic            b_valid,
   output logic            b_hazard,
   output logic [PC_W-1:0] b_addr,
   output logic            b_taken,
   output logic [PC_W-1:0] b_pc,
   output logic            md_valid,
   output logic [RA_W-1:0] md_addr,
   output logic [XLEN-1:0] md_val
);

   localparam int unsigned SH_W  = $clog2(XLEN);
   localparam int unsigned CNT_W = $clog2(XLEN);

   localparam logic [5:0] OP_ADD  = 6'b001100, OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SUB  = 6'b010100;
   localparam logic [5:0] OP_SLL  = 6'b011100, OP_SLLI = 6'b011000;
   localparam logic [5:0] OP_SRL  = 6'b100100, OP_SRLI = 6'b100000;
   localparam logic [5:0] OP_SRA  = 6'b101100, OP_SRAI = 6'b101000;
   localparam logic [5:0] OP_LUI  = 6'b110000;
   localparam logic [5:0] OP_J    = 6'b000010, OP_JAL  = 6'b000110;
   localparam logic [5:0] OP_JR   = 6'b001010, OP_JALR = 6'b001110;
   localparam logic [5:0] OP_BEQ  = 6'b010010, OP_BLE  = 6'b011010;
   localparam logic [5:0] OP_BEQI = 6'b110010, OP_BNEI = 6'b111010;
   localparam logic [5:0] OP_BLEI = 6'b100010, OP_BGEI = 6'b101010;
   localparam logic [5:0] OP_MUL  = 6'b110100, OP_DIV  = 6'b111100;
   localparam logic [5:0] OP_REM  = 6'b111000;

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;
   typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} md_op_t;
   typedef enum logic [1:0] {SP_NONE, SP_DIV0, SP_OVF} special_t;

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state_q, state_d;
   md_op_t          op_q, op_d;
   special_t        spec_q, spec_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d, div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RA_W-1:0] dst_q, dst_d;

   logic [RA_W-1:0] alu_addr_q, alu_addr_d;
   logic [XLEN-1:0] alu_val_q, alu_val_d;
   logic            b_valid_q, b_valid_d, b_hazard_q, b_hazard_d;
   logic            b_taken_q, b_taken_d;
   logic [PC_W-1:0] b_addr_q, b_addr_d, b_pc_q, b_pc_d;
   logic            md_valid_q, md_valid_d;
   logic [RA_W-1:0] md_addr_q, md_addr_d;
   logic [XLEN-1:0] md_val_q, md_val_d;

   logic [XLEN-1:0] ex_imm, opr_x, rt, lui_val, link_val;
   logic [SH_W-1:0] sh;
   logic [PC_W-1:0] pc_inc;
   logic            accept, cond;
   logic [XLEN:0]   step_r;
   logic [XLEN-1:0] abs_a, abs_b;

   assign busy   = (state_q != S_IDLE);
   assign accept = in_valid & ~busy & ~flush;

   assign ex_imm   = XLEN'($signed(imm));
   assign opr_x    = XLEN'($signed(opr));
   assign rt       = ope[2] ? dt_val : ex_imm;
   assign sh       = rt[SH_W-1:0];
   assign pc_inc   = pc + PC_W'(1);
   // Link value keeps the carry out of the PC width; the redirect address wraps.
   assign link_val = XLEN'({1'b0, pc} + (PC_W+1)'(1));
   assign abs_a    = a_q[XLEN-1] ? -a_q : a_q;
   assign abs_b    = b_q[XLEN-1] ? -b_q : b_q;
   assign step_r   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};

   generate
      if (XLEN > 16) begin : g_lui_wide
         assign lui_val = {imm, ds_val[XLEN-17:0]};
      end else begin : g_lui_narrow
         assign lui_val = imm[XLEN-1:0];
      end
   endgenerate

   always_comb begin
      cond = 1'b0;
      unique case (ope)
         OP_BEQ:  cond = (ds_val == dt_val);
         OP_BLE:  cond = ($signed(ds_val) <= $signed(dt_val));
         OP_BEQI: cond = (ds_val == opr_x);
         OP_BNEI: cond = (ds_val != opr_x);
         OP_BLEI: cond = ($signed(ds_val) <= $signed(opr_x));
         OP_BGEI: cond = ($signed(ds_val) >= $signed(opr_x));
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      spec_d     = spec_q;
      neg_d      = neg_q;
      a_d        = a_q;
      b_d        = b_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      dst_d      = dst_q;
      alu_addr_d = '0;
      alu_val_d  = '0;
      b_valid_d  = 1'b0;
      b_hazard_d = 1'b0;
      b_taken_d  = 1'b0;
      b_addr_d   = '0;
      b_pc_d     = '0;
      md_valid_d = 1'b0;
      md_addr_d  = md_addr_q;
      md_val_d   = md_val_q;

      if (accept) begin
         unique case (ope)
            OP_ADD, OP_ADDI: begin alu_addr_d = dd; alu_val_d = ds_val + rt; end
            OP_SUB:          begin alu_addr_d = dd; alu_val_d = ds_val - rt; end
            OP_SLL, OP_SLLI: begin alu_addr_d = dd; alu_val_d = ds_val << sh; end
            OP_SRL, OP_SRLI: begin alu_addr_d = dd; alu_val_d = ds_val >> sh; end
            OP_SRA, OP_SRAI: begin
               alu_addr_d = dd;
               alu_val_d  = XLEN'($signed(ds_val) >>> sh);
            end
            OP_LUI:          begin alu_addr_d = dd; alu_val_d = lui_val; end
            OP_J, OP_JAL, OP_JR, OP_JALR: begin
               b_valid_d  = 1'b1;
               b_taken_d  = 1'b1;
               b_pc_d     = pc;
               b_hazard_d = ope[3];
               b_addr_d   = ope[3] ? ds_val[PC_W-1:0] : imm[PC_W-1:0];
               if (ope[2]) begin
                  alu_addr_d = RA_W'(LINK_REG);
                  alu_val_d  = link_val;
               end
            end
            OP_BEQ, OP_BLE, OP_BEQI, OP_BNEI, OP_BLEI, OP_BGEI: begin
               b_valid_d  = 1'b1;
               b_taken_d  = cond;
               b_pc_d     = pc;
               b_hazard_d = cond ^ pred_taken;
               b_addr_d   = cond ? imm[PC_W-1:0] : pc_inc;
            end
            OP_MUL, OP_DIV, OP_REM: begin
               state_d = S_PREP;
               op_d    = (ope == OP_MUL) ? MD_MUL : (ope == OP_DIV) ? MD_DIV : MD_REM;
               a_d     = ds_val;
               b_d     = rt;
               dst_d   = dd;
            end
            default: ;
         endcase
      end

      unique case (state_q)
         S_PREP: begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(XLEN-1);
            rem_d   = '0;
            spec_d  = SP_NONE;
            if (op_q == MD_MUL) begin
               quo_d = b_q;
               div_d = a_q;
               neg_d = 1'b0;
            end else begin
               quo_d = abs_a;
               div_d = abs_b;
               neg_d = (op_q == MD_DIV) ? (a_q[XLEN-1] ^ b_q[XLEN-1]) : a_q[XLEN-1];
               if (b_q == '0)
                  spec_d = SP_DIV0;
               else if (a_q == MIN_VAL && b_q == '1)
                  spec_d = SP_OVF;
            end
         end
         S_RUN: begin
            // Multiply walks the multiplier MSB-first; divide shifts the
            // dividend out of quo_q into the partial remainder.
            if (op_q == MD_MUL) begin
               rem_d = {1'b0, {rem_q[XLEN-2:0], 1'b0} + (quo_q[XLEN-1] ? div_q : '0)};
               quo_d = quo_q << 1;
            end else if (step_r >= {1'b0, div_q}) begin
               rem_d = step_r - {1'b0, div_q};
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = step_r;
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_FIX: begin
            state_d    = S_IDLE;
            md_valid_d = 1'b1;
            md_addr_d  = dst_q;
            unique case (op_q)
               MD_MUL: md_val_d = rem_q[XLEN-1:0];
               MD_DIV: md_val_d = (spec_q == SP_DIV0) ? '1 :
                                  (spec_q == SP_OVF)  ? MIN_VAL :
                                  neg_q ? -quo_q : quo_q;
               default: md_val_d = (spec_q == SP_DIV0) ? a_q :
                                   (spec_q == SP_OVF)  ? '0 :
                                   neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
            endcase
         end
         default: ;
      endcase

      if (flush && state_q != S_IDLE) begin
         state_d    = S_IDLE;
         md_valid_d = 1'b0;
         md_addr_d  = md_addr_q;
         md_val_d   = md_val_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         op_q       <= MD_MUL;
         spec_q     <= SP_NONE;
         neg_q      <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         div_q      <= '0;
         cnt_q      <= '0;
         dst_q      <= '0;
         alu_addr_q <= '0;
         alu_val_q  <= '0;
         b_valid_q  <= 1'b0;
         b_hazard_q <= 1'b0;
         b_taken_q  <= 1'b0;
         b_addr_q   <= '0;
         b_pc_q     <= '0;
         md_valid_q <= 1'b0;
         md_addr_q  <= '0;
         md_val_q   <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         spec_q     <= spec_d;
         neg_q      <= neg_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         dst_q      <= dst_d;
         alu_addr_q <= alu_addr_d;
         alu_val_q  <= alu_val_d;
         b_valid_q  <= b_valid_d;
         b_hazard_q <= b_hazard_d;
         b_taken_q  <= b_taken_d;
         b_addr_q   <= b_addr_d;
         b_pc_q     <= b_pc_d;
         md_valid_q <= md_valid_d;
         md_addr_q  <= md_addr_d;
         md_val_q   <= md_val_d;
      end
   end

   assign alu_addr = alu_addr_q;
   assign alu_val  = alu_val_q;
   assign b_valid  = b_valid_q;
   assign b_hazard = b_hazard_q;
   assign b_addr   = b_addr_q;
   assign b_taken  = b_taken_q;
   assign b_pc     = b_pc_q;
   assign md_valid = md_valid_q;
   assign md_addr  = md_addr_q;
   assign md_val   = md_val_q;

endmodule

// File: tb/tb_exec_unit_md.sv
// Directed bench for exec_unit_md: default 32-bit instance plus a 16-bit
// instance sharing control inputs for the narrow-width latency case.
module tb_exec_unit_md;

   logic        clk = 1'b0;
   logic        rstn, in_valid, flush, pred_taken;
   logic [13:0] pc;
   logic [5:0]  ope, dd;
   logic [31:0] ds_val, dt_val;
   logic [15:0] imm;
   logic [4:0]  opr;

   logic        busy, b_valid, b_hazard, b_taken, md_valid;
   logic [5:0]  alu_addr, md_addr;
   logic [31:0] alu_val, md_val;
   logic [13:0] b_addr, b_pc;

   logic [15:0] ds16, dt16;
   logic        busy16, b_valid16, b_hazard16, b_taken16, md_valid16;
   logic [5:0]  alu_addr16, md_addr16;
   logic [15:0] alu_val16, md_val16;
   logic [13:0] b_addr16, b_pc16;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   assign ds16 = ds_val[15:0];
   assign dt16 = dt_val[15:0];

   always #5 clk = ~clk;

   exec_unit_md u_dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .flush(flush), .pc(pc), .ope(ope),
      .ds_val(ds_val), .dt_val(dt_val), .dd(dd), .imm(imm), .opr(opr),
      .pred_taken(pred_taken), .busy(busy), .alu_addr(alu_addr), .alu_val(alu_val),
      .b_valid(b_valid), .b_hazard(b_hazard), .b_addr(b_addr), .b_taken(b_taken),
      .b_pc(b_pc), .md_valid(md_valid), .md_addr(md_addr), .md_val(md_val)
   );

   exec_unit_md #(.XLEN(16)) u_dut16 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .flush(flush), .pc(pc), .ope(ope),
      .ds_val(ds16), .dt_val(dt16), .dd(dd), .imm(imm), .opr(opr),
      .pred_taken(pred_taken), .busy(busy16), .alu_addr(alu_addr16), .alu_val(alu_val16),
      .b_valid(b_valid16), .b_hazard(b_hazard16), .b_addr(b_addr16), .b_taken(b_taken16),
      .b_pc(b_pc16), .md_valid(md_valid16), .md_addr(md_addr16), .md_val(md_val16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] d, input logic [15:0] im, input logic [4:0] o,
                        input logic pt, input logic [13:0] p);
      in_valid = 1'b1; ope = op; ds_val = a; dt_val = b; dd = d;
      imm = im; opr = o; pred_taken = pt; pc = p;
   endtask

   task automatic nop();
      in_valid = 1'b0; ope = 6'b0; ds_val = '0; dt_val = '0; dd = '0;
      imm = '0; opr = '0; pred_taken = 1'b0; pc = '0;
   endtask

   task automatic alu_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] im, input logic [5:0] d,
                         input logic [31:0] exp);
      drive(op, a, b, d, im, 5'd0, 1'b0, 14'd0);
      tick();
      nop();
      chk({tag, "_addr"}, {26'd0, alu_addr}, {26'd0, d});
      chk({tag, "_val"}, alu_val, exp);
   endtask

   task automatic br_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] im, input logic [4:0] o,
                        input logic pt, input logic [13:0] p, input logic tk,
                        input logic [13:0] tgt, input logic hz);
      drive(op, a, b, 6'd5, im, o, pt, p);
      tick();
      nop();
      chk({tag, "_valid"}, {31'd0, b_valid}, 32'd1);
      chk({tag, "_taken"}, {31'd0, b_taken}, {31'd0, tk});
      chk({tag, "_target"}, {18'd0, b_addr}, {18'd0, tgt});
      chk({tag, "_hazard"}, {31'd0, b_hazard}, {31'd0, hz});
      chk({tag, "_pc"}, {18'd0, b_pc}, {18'd0, p});
      chk({tag, "_noalu"}, {26'd0, alu_addr}, 32'd0);
   endtask

   // Accept at T; busy over T+1..T+34, result pulse at T+35.
   task automatic md_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] im, input logic [5:0] d,
                        input logic [31:0] exp, input bit hold_add);
      int unsigned bad;
      drive(op, a, b, d, im, 5'd0, 1'b0, 14'd0);
      tick();
      if (hold_add) drive(6'b001100, 32'd1, 32'd1, 6'd7, 16'd0, 5'd0, 1'b0, 14'd0);
      else          nop();
      bad = 0;
      for (int i = 1; i <= 34; i++) begin
         if (busy !== 1'b1 || md_valid !== 1'b0 || alu_addr !== 6'd0) bad++;
         tick();
      end
      chk({tag, "_window"}, bad, 32'd0);
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_mdvalid"}, {31'd0, md_valid}, 32'd1);
      chk({tag, "_mdaddr"}, {26'd0, md_addr}, {26'd0, d});
      chk({tag, "_mdval"}, md_val, exp);
      chk({tag, "_alu_idle"}, {26'd0, alu_addr}, 32'd0);
      tick();
      nop();
      chk({tag, "_pulse"}, {31'd0, md_valid}, 32'd0);
      if (hold_add) begin
         chk({tag, "_held_addr"}, {26'd0, alu_addr}, 32'd7);
         chk({tag, "_held_val"}, alu_val, 32'd2);
      end
   endtask

   initial begin
      int unsigned bad, lat;
      nop();
      flush = 1'b0;
      rstn  = 1'b0;
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_alu_addr", {26'd0, alu_addr}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_md_valid", {31'd0, md_valid}, 32'd0);
      chk("rst_md_val", md_val, 32'd0);
      rstn = 1'b1;
      tick();

      alu_op("addi", 6'b001000, 32'd5, 32'd0, 16'hFFFF, 6'd3, 32'd4);
      alu_op("sra", 6'b101100, 32'h8000_0000, 32'd4, 16'd0, 6'd5, 32'hF800_0000);
      alu_op("sub", 6'b010100, 32'd3, 32'd5, 16'd0, 6'd6, 32'hFFFF_FFFE);
      alu_op("slli", 6'b011000, 32'd1, 32'd0, 16'h001F, 6'd8, 32'h8000_0000);
      alu_op("srli", 6'b100000, 32'h8000_0000, 32'd0, 16'h0021, 6'd9, 32'h4000_0000);
      alu_op("lui", 6'b110000, 32'h1234_5678, 32'd0, 16'hABCD, 6'd10, 32'hABCD_5678);

      br_op("blei_np", 6'b100010, 32'hFFFF_FFFD, 32'd0, 16'h0200, 5'b11101, 1'b0,
            14'd100, 1'b1, 14'h0200, 1'b1);
      br_op("blei_p", 6'b100010, 32'hFFFF_FFFD, 32'd0, 16'h0200, 5'b11101, 1'b1,
            14'd100, 1'b1, 14'h0200, 1'b0);
      br_op("beq_wrap", 6'b010010, 32'd1, 32'd2, 16'h0010, 5'd0, 1'b1,
            14'h3FFF, 1'b0, 14'h0000, 1'b1);
      br_op("bgei", 6'b101010, 32'd0, 32'd0, 16'h0040, 5'b10000, 1'b0,
            14'd7, 1'b1, 14'h0040, 1'b1);

      drive(6'b001110, 32'h0000_1234, 32'd0, 6'd2, 16'd0, 5'd0, 1'b0, 14'h3FFF);
      tick();
      nop();
      chk("jalr_valid", {31'd0, b_valid}, 32'd1);
      chk("jalr_hazard", {31'd0, b_hazard}, 32'd1);
      chk("jalr_target", {18'd0, b_addr}, 32'h1234);
      chk("jalr_link_addr", {26'd0, alu_addr}, 32'd31);
      chk("jalr_link_val", alu_val, 32'h4000);
      tick();
      chk("nop_alu", {26'd0, alu_addr}, 32'd0);
      chk("nop_b", {31'd0, b_valid}, 32'd0);

      drive(6'b111111, 32'd1, 32'd1, 6'd4, 16'd0, 5'd0, 1'b0, 14'd0);
      tick();
      nop();
      chk("unk_alu", {26'd0, alu_addr}, 32'd0);
      chk("unk_b", {31'd0, b_valid}, 32'd0);
      chk("unk_busy", {31'd0, busy}, 32'd0);

      md_op("div", 6'b111100, 32'hFFFF_FFF9, 32'd2, 16'd2, 6'd9, 32'hFFFF_FFFD, 1'b1);
      md_op("rem", 6'b111000, 32'hFFFF_FFF9, 32'd2, 16'd2, 6'd9, 32'hFFFF_FFFF, 1'b0);
      md_op("div0", 6'b111100, 32'd17, 32'd0, 16'd0, 6'd11, 32'hFFFF_FFFF, 1'b0);
      md_op("rem0", 6'b111000, 32'd17, 32'd0, 16'd0, 6'd12, 32'd17, 1'b0);
      md_op("div_ovf", 6'b111100, 32'h8000_0000, 32'hFFFF_FFFF, 16'hFFFF, 6'd13,
            32'h8000_0000, 1'b0);
      md_op("mul", 6'b110100, 32'hFFFF_FFFF, 32'd3, 16'd3, 6'd14, 32'hFFFF_FFFD, 1'b0);
      md_op("div_pn", 6'b111100, 32'd7, 32'hFFFF_FFFD, 16'hFFFD, 6'd15, 32'hFFFF_FFFE, 1'b0);
      md_op("rem_pn", 6'b111000, 32'd7, 32'hFFFF_FFFD, 16'hFFFD, 6'd16, 32'd1, 1'b0);

      drive(6'b001100, 32'd10, 32'd20, 6'd20, 16'd0, 5'd0, 1'b0, 14'd0);
      tick();
      drive(6'b001100, 32'd1, 32'd1, 6'd21, 16'd0, 5'd0, 1'b0, 14'd0);
      flush = 1'b1;
      chk("flush_prev_addr", {26'd0, alu_addr}, 32'd20);
      chk("flush_prev_val", alu_val, 32'd30);
      tick();
      nop();
      flush = 1'b0;
      chk("flush_blocks_issue", {26'd0, alu_addr}, 32'd0);

      drive(6'b111100, 32'd100, 32'd7, 6'd22, 16'd7, 5'd0, 1'b0, 14'd0);
      tick();
      nop();
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      bad = 0;
      repeat (40) begin
         if (md_valid !== 1'b0) bad++;
         tick();
      end
      chk("flush_no_md", bad, 32'd0);

      drive(6'b110100, 32'd5, 32'd6, 6'd23, 16'd6, 5'd0, 1'b0, 14'd0);
      tick();
      nop();
      repeat (5) tick();
      rstn = 1'b0;
      tick();
      chk("rrun_busy", {31'd0, busy}, 32'd0);
      chk("rrun_md_valid", {31'd0, md_valid}, 32'd0);
      chk("rrun_md_addr", {26'd0, md_addr}, 32'd0);
      chk("rrun_md_val", md_val, 32'd0);
      chk("rrun_alu_addr", {26'd0, alu_addr}, 32'd0);
      rstn = 1'b1;
      bad = 0;
      repeat (40) begin
         if (md_valid !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      chk("rrun_discarded", bad, 32'd0);

      drive(6'b110100, 32'h0000_00FF, 32'h0000_0101, 6'd2, 16'h0101, 5'd0, 1'b0, 14'd0);
      tick();
      nop();
      lat = 1;
      while (md_valid16 !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      chk("x16_latency", lat, 32'd19);
      chk("x16_mul", {16'd0, md_val16}, 32'h0000_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/exec_unit_md.md
Name: exec_unit_md

Overview:
- Parametrised successor to the single-cycle branch/ALU execution unit in the core pipeline.
- Keeps the single-cycle ALU and branch-resolution paths and adds an iterative multiply/divide/remainder engine.
- The engine has a valid/busy issue handshake, a separate writeback channel and flush support.
- Sits between the issue stage (operands read) and writeback/fetch redirect.

Parameters:
- XLEN, 32, data path width (>=8, even).
- PC_W, 14, program-counter width (<=16).
- RA_W, 6, destination register address width.
- LINK_REG, 31, register written by JAL/JALR.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- in_valid  in  1  instruction offered this cycle.
- flush  in  1  kill in-flight mul/div and ignore this cycle's in_valid.
- pc  in  PC_W  instruction PC.
- ope  in  6  opcode.
- ds_val  in  XLEN  rs operand.
- dt_val  in  XLEN  rt operand.
- dd  in  RA_W  destination register.
- imm  in  16  immediate.
- opr  in  5  signed compare immediate.
- pred_taken  in  1  predicted direction.
- busy  out  1  engine occupied; issue not accepted.
- alu_addr  out  RA_W  single-cycle write address (0 = no write).
- alu_val  out  XLEN  single-cycle result.
- b_valid  out  1  branch/jump resolved this cycle.
- b_hazard  out  1  redirect required.
- b_addr  out  PC_W  redirect target.
- b_taken  out  1  actual direction.
- b_pc  out  PC_W  PC of resolved branch.
- md_valid  out  1  mul/div result pulse.
- md_addr  out  RA_W  mul/div destination.
- md_val  out  XLEN  mul/div result.

Behaviour:
- Reset, and the cycle after any reset cycle: every output is 0, the FSM is in IDLE, any in-flight operation is discarded.
- Accept condition: in_valid & ~busy & ~flush. An unaccepted cycle behaves as a NOP: alu_addr=0, b_valid=0.
- busy is combinational from the FSM state.
- Immediate ex_imm is sign-extended imm. The rt operand is dt_val when ope[2]=1, otherwise ex_imm.
- Single-cycle ALU ops are registered with 1-cycle latency. alu_addr=dd.
  - ADD 001100 / ADDI 001000: sum.
  - SUB 010100: difference.
  - SLL 011100 / SLLI 011000: logical left shift by operand[log2(XLEN)-1:0].
  - SRL 100100 / SRLI 100000: logical right shift, same amount.
  - SRA 101100 / SRAI 101000: arithmetic right shift, same amount.
  - LUI 110000: {imm, ds_val[XLEN-17:0]}.
  - All arithmetic wraps modulo 2^XLEN.
- Jumps (1-cycle latency, b_valid=1):
  - J 000010: b_hazard=0, alu_addr=0.
  - JAL 000110: b_hazard=0, alu_addr=LINK_REG, alu_val=pc+1 zero-extended.
  - JR 001010: b_hazard=1, b_addr=ds_val[PC_W-1:0], alu_addr=0.
  - JALR 001110: as JR, plus link write as JAL.
- Conditional branches (b_valid=1, alu_addr=0); compares are signed, opr is sign-extended:
  - BEQ 010010: ds==dt.
  - BLE 011010: ds<=dt.
  - BEQI 110010: ds==opr.
  - BNEI 111010: ds!=opr.
  - BLEI 100010: ds<=opr.
  - BGEI 101010: ds>=opr.
  - b_taken = condition. b_addr = taken ? imm[PC_W-1:0] : pc+1 (wraps at 2^PC_W). b_hazard = taken ^ pred_taken. b_pc = pc.
- Mul/div ops; accepting one produces alu_addr=0 that cycle:
  - MUL 110100: low XLEN bits of the product.
  - DIV 111100: signed quotient, truncating toward zero.
  - REM 111000: signed remainder, sign of dividend.
- Mul/div FSM: IDLE → PREP → RUN → FIX → IDLE.
  - Accept at cycle T in IDLE.
  - PREP (T+1): latch magnitudes and signs.
  - RUN (T+2 .. T+1+XLEN): one radix-2 shift-add or restoring-subtract step per cycle; the counter counts XLEN-1 down to 0.
  - FIX (T+2+XLEN): apply sign correction, register md_addr/md_val.
  - md_valid=1 during exactly cycle T+3+XLEN, with the FSM back in IDLE.
- busy=1 exactly for cycles T+1 .. T+2+XLEN. A new op may be accepted in the md_valid cycle.
- Divide special cases:
  - Divisor 0: quotient = all ones, remainder = dividend.
  - MIN / -1: quotient = MIN, remainder = 0.
  - Decided in PREP; latency is unchanged.
- flush in any non-IDLE state: next state IDLE, md_valid stays 0, busy drops the following cycle.
  - flush has priority over the FIX→md_valid transition.
  - flush does not affect alu_*/b_* of an op accepted in the previous cycle.
- Unknown opcodes: alu_addr=0, b_valid=0, FSM untouched.

Test Plan:
- ADDI ds=5, imm=0xFFFF, dd=3 → next cycle alu_addr=3, alu_val=4. SRA ds=0x80000000, dt=4 → 0xF8000000.
- BLEI pc=100, ds=-3, opr=-3, imm=0x0200, pred_taken=0 → b_valid=1, b_taken=1, b_addr=0x200, b_hazard=1, b_pc=100. Same op with pred_taken=1 → b_hazard=0.
- DIV ds=-7, dt=2, dd=9 accepted at T → busy=1 during T+1..T+34, md_valid only at T+35 with md_addr=9, md_val=-3. REM same operands → md_val=-1.
- DIV by 0 (ds=17) → md_val=0xFFFFFFFF. REM by 0 → 17. DIV 0x80000000 / -1 → 0x80000000. MUL 0xFFFFFFFF*3 → 0xFFFFFFFD.
- in_valid ADD held during busy → no alu write until md_valid cycle. flush at T+10 → md_valid never asserts, busy=0 at T+11. rstn=0 mid-RUN → all outputs 0 the next cycle.
- JALR pc=0x3FFF, ds=0x1234 → b_hazard=1, b_addr=0x1234, alu_addr=31, alu_val=0x4000. With XLEN=16 the MUL/DIV latency is 19 cycles.
